multi_clock_divider: RTL and testbench

MULTI_CLOCK_DIVIDER -- requirements
Module: multi_clock_divider

---
 rtl/multi_clock_divider.sv | 136 +++++++++++++
 tb/tb_multi_clock_divider.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider. Each channel counts a period P with
// high time H; new settings wait in a pending slot and load at the period wrap.
module multi_clock_divider #(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 50,
  parameter int DEF_HIGH   = 25,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [NUM_CH-1:0] enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_PERIOD = (DEF_PERIOD < 2) ? MIN_PERIOD : CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(DEF_HIGH);

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [CNT_W-1:0]  per_q   [NUM_CH];
  logic [CNT_W-1:0]  per_d   [NUM_CH];
  logic [CNT_W-1:0]  high_q  [NUM_CH];
  logic [CNT_W-1:0]  high_d  [NUM_CH];
  logic [CNT_W-1:0]  nper_q  [NUM_CH];
  logic [CNT_W-1:0]  nper_d  [NUM_CH];
  logic [CNT_W-1:0]  nhigh_q [NUM_CH];
  logic [CNT_W-1:0]  nhigh_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] cfg_sel_s, wrap_s, apply_s, load_s;
  logic              cfg_fire_s;

  // One-hot channel select; an out-of-range cfg_ch selects nothing.
  always_comb begin
    cfg_sel_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_sel_s[i] = (int'(cfg_ch) == i);
    end
  end

  assign cfg_ready  = ~|(pend_q & cfg_sel_s);
  assign cfg_fire_s = cfg_valid & cfg_ready;

  // Per-channel next state: count, pending-slot handling and output decode.
  always_comb begin
    cnt_d   = cnt_q;
    per_d   = per_q;
    high_d  = high_q;
    nper_d  = nper_q;
    nhigh_d = nhigh_q;
    pend_d  = pend_q;
    run_d   = enable;
    clk_d   = '0;
    tick_d  = '0;
    wrap_s  = '0;
    apply_s = '0;
    load_s  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wrap_s[i]  = run_q[i] && (cnt_q[i] == per_q[i] - CNT_W'(1));
      // A stopped channel has no period in flight, so it may reload at once.
      apply_s[i] = pend_q[i] && (!enable[i] || !run_q[i] || wrap_s[i]);
      load_s[i]  = cfg_fire_s && cfg_sel_s[i];

      if (!enable[i] || !run_q[i] || wrap_s[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      if (apply_s[i]) begin
        per_d[i]  = nper_q[i];
        high_d[i] = nhigh_q[i];
      end else begin
        per_d[i]  = per_q[i];
        high_d[i] = high_q[i];
      end

      if (load_s[i]) begin
        nper_d[i]  = clamp_period(cfg_period);
        nhigh_d[i] = cfg_high;
      end else begin
        nper_d[i]  = nper_q[i];
        nhigh_d[i] = nhigh_q[i];
      end

      pend_d[i] = load_s[i] | (pend_q[i] & ~apply_s[i]);
      clk_d[i]  = enable[i] && (cnt_d[i] < high_d[i]);
      tick_d[i] = enable[i] && (cnt_d[i] == per_d[i] - CNT_W'(1));
    end
  end

  // State registers with asynchronous reset to the default configuration.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]   <= '0;
        per_q[i]   <= RST_PERIOD;
        high_q[i]  <= RST_HIGH;
        nper_q[i]  <= RST_PERIOD;
        nhigh_q[i] <= RST_HIGH;
      end
      pend_q <= '0;
      run_q  <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      high_q  <= high_d;
      nper_q  <= nper_d;
      nhigh_q <= nhigh_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomized and directed bench for multi_clock_divider, checked against a
// period/phase reference model of each channel.
module tb_multi_clock_divider;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [1:0]  enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_period;
  logic [15:0] cfg_high;
  logic [1:0]  clk_out;
  logic [1:0]  tick;

  logic [2:0]  enable3;
  logic        cfg_valid3;
  logic        cfg_ready3;
  logic [1:0]  cfg_ch3;
  logic [15:0] cfg_period3;
  logic [15:0] cfg_high3;
  logic [2:0]  clk_out3;
  logic [2:0]  tick3;

  always #5 clk_in = ~clk_in;

  multi_clock_divider u_dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_high(cfg_high), .clk_out(clk_out), .tick(tick)
  );

  multi_clock_divider #(.NUM_CH(3)) u_dut3 (
    .clk_in(clk_in), .reset(reset), .enable(enable3), .cfg_valid(cfg_valid3),
    .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3), .cfg_period(cfg_period3),
    .cfg_high(cfg_high3), .clk_out(clk_out3), .tick(tick3)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: active period/high, pending slot, position inside the period.
  int m_p[2], m_h[2], m_pp[2], m_hp[2], m_phase[2];
  bit m_pend[2], m_run[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 50; m_h[i] = 25; m_pp[i] = 50; m_hp[i] = 25;
      m_phase[i] = 0; m_pend[i] = 1'b0; m_run[i] = 1'b0;
    end
  endtask

  function automatic logic [1:0] exp_clk();
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < 2; i++) r[i] = m_run[i] && (m_phase[i] < m_h[i]);
    return r;
  endfunction

  function automatic logic [1:0] exp_tick();
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < 2; i++) r[i] = m_run[i] && (m_phase[i] == m_p[i] - 1);
    return r;
  endfunction

  function automatic logic exp_ready();
    return !m_pend[int'(cfg_ch)];
  endfunction

  // Advance one clock; model consumes the inputs present at the edge.
  task automatic step(output bit acc);
    int ch;
    bit a;
    bit apply;
    ch = int'(cfg_ch);
    a = cfg_valid && !m_pend[ch] && !reset;
    @(posedge clk_in);
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        apply = m_pend[i] && (!enable[i] || !m_run[i] || (m_phase[i] == m_p[i] - 1));
        if (!enable[i]) begin
          m_run[i] = 1'b0; m_phase[i] = 0;
        end else if (!m_run[i]) begin
          m_run[i] = 1'b1; m_phase[i] = 0;
        end else begin
          m_phase[i] = (m_phase[i] + 1) % m_p[i];
        end
        if (apply) begin
          m_p[i] = m_pp[i]; m_h[i] = m_hp[i]; m_pend[i] = 1'b0;
        end
        if (a && ch == i) begin
          m_pend[i] = 1'b1;
          m_pp[i] = (cfg_period < 16'd2) ? 2 : int'(cfg_period);
          m_hp[i] = int'(cfg_high);
        end
      end
    end
    #1;
    acc = a;
  endtask

  task automatic adv();
    bit d;
    step(d);
  endtask

  task automatic test_reset();
    #2; reset = 1'b1; model_reset(); #1;
    checks++;
    if (clk_out !== 2'b00 || tick !== 2'b00) begin
      failures++; $display("FAIL reset_async: clk_out=%b tick=%b expected 00 00", clk_out, tick);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: cfg_ready=%b expected 1", cfg_ready);
    end
    adv(); adv();
    reset = 1'b0;
    adv();
    checks++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_after: clk_out=%b tick=%b ready=%b expected 00 00 1", clk_out, tick, cfg_ready);
    end
  endtask

  task automatic test_defaults();
    logic [1:0] ec, et;
    enable = 2'b01;
    for (int k = 0; k < 150; k++) begin
      adv();
      ec = 2'b00; et = 2'b00;
      ec[0] = (k % 50) < 25;
      et[0] = (k % 50) == 49;
      checks++;
      if (clk_out !== ec || tick !== et) begin
        failures++; $display("FAIL defaults k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, ec, et);
      end
    end
  endtask

  task automatic test_glitch_free();
    int n;
    n = 0;
    while (m_phase[0] != 20 && n < 100) begin
      adv(); n++;
      checks++;
      if (clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL glitch_pre: clk_out=%b tick=%b expected %b %b", clk_out, tick, exp_clk(), exp_tick());
      end
    end
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_period = 16'd10; cfg_high = 16'd3; #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL glitch_accept: cfg_ready=%b expected 1", cfg_ready);
    end
    adv();
    cfg_valid = 1'b0;
    n = 0;
    while (tick[0] !== 1'b1 && n < 60) begin
      checks++;
      if (cfg_ready !== 1'b0) begin
        failures++; $display("FAIL glitch_hold_ready: cfg_ready=%b expected 0", cfg_ready);
      end
      adv(); n++;
      checks++;
      if (clk_out[0] !== ((m_phase[0] < 25) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL glitch_old_period: clk_out0=%b expected %b", clk_out[0], (m_phase[0] < 25));
      end
    end
    checks++;
    if (n != 28) begin
      failures++; $display("FAIL glitch_wrap_len: cycles to old tick=%0d expected 28", n);
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++; $display("FAIL glitch_ready_at_wrap: cfg_ready=%b expected 0", cfg_ready);
    end
    for (int k = 0; k < 30; k++) begin
      adv();
      checks++;
      if (clk_out[0] !== ((k % 10) < 3) || tick[0] !== ((k % 10) == 9)) begin
        failures++; $display("FAIL glitch_new k=%0d: clk0=%b tick0=%b expected %b %b", k, clk_out[0], tick[0], (k % 10) < 3, (k % 10) == 9);
      end
    end
  endtask

  task automatic test_edge_cases();
    int n;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_period = 16'd1; cfg_high = 16'd0; #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL edge_accept: cfg_ready=%b expected 1", cfg_ready);
    end
    adv();
    cfg_valid = 1'b0;
    adv();
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL edge_disabled_apply: cfg_ready=%b expected 1", cfg_ready);
    end
    enable = 2'b11;
    for (int k = 0; k < 20; k++) begin
      adv();
      checks++;
      if (clk_out[1] !== 1'b0 || tick[1] !== ((k % 2) == 1) || clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL edge_p2 k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, exp_clk(), exp_tick());
      end
    end
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_period = 16'd4; cfg_high = 16'd5; #1;
    adv();
    cfg_valid = 1'b0;
    n = 0;
    while (m_pend[1] && n < 10) begin
      adv(); n++;
      checks++;
      if (clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL edge_wait: clk_out=%b tick=%b expected %b %b", clk_out, tick, exp_clk(), exp_tick());
      end
    end
    for (int k = 0; k < 12; k++) begin
      adv();
      checks++;
      if (clk_out[1] !== 1'b1 || clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL edge_h_ge_p k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, exp_clk(), exp_tick());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_period = 16'd6; cfg_high = 16'd2; #1;
    step(acc);
    cfg_period = 16'd8; cfg_high = 16'd4; #1;
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_refuse: cfg_ready=%b expected 0", cfg_ready);
    end
    adv();
    cfg_ch = 1'b1; cfg_period = 16'd12; cfg_high = 16'd6; #1;
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_other_ch: cfg_ready=%b expected 1", cfg_ready);
    end
    adv();
    cfg_ch = 1'b0; cfg_period = 16'd8; cfg_high = 16'd4; #1;
    acc = 1'b0; n = 0;
    while (!acc && n < 30) begin
      checks++;
      if (cfg_ready !== exp_ready()) begin
        failures++; $display("FAIL b2b_held_ready: cfg_ready=%b expected %b", cfg_ready, exp_ready());
      end
      step(acc); n++;
      checks++;
      if (clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL b2b_held_out: clk_out=%b tick=%b expected %b %b", clk_out, tick, exp_clk(), exp_tick());
      end
    end
    checks++;
    if (!acc) begin
      failures++; $display("FAIL b2b_timeout: held request not taken in %0d cycles, expected within 30", n);
    end
    cfg_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      adv();
      checks++;
      if (clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL b2b_after k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, exp_clk(), exp_tick());
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic e;
    reset = 1'b1; model_reset(); #3; reset = 1'b0;
    enable = 2'b01;
    for (int k = 0; k < 10; k++) adv();
    enable = 2'b11;
    n = 0;
    while (m_phase[0] != 20 && n < 60) begin
      adv(); n++;
    end
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_period = 16'd10; cfg_high = 16'd3; #1;
    adv();
    cfg_valid = 1'b0;
    n = 0;
    while (m_phase[0] != 30 && n < 60) begin
      adv(); n++;
    end
    checks++;
    if (clk_out !== 2'b10 || tick !== 2'b00) begin
      failures++; $display("FAIL areset_pre: clk_out=%b tick=%b expected 10 00", clk_out, tick);
    end
    #2; reset = 1'b1; model_reset(); #1;
    checks++;
    if (clk_out !== 2'b00 || tick !== 2'b00 || cfg_ready !== 1'b1) begin
      failures++; $display("FAIL areset_drop: clk_out=%b tick=%b ready=%b expected 00 00 1", clk_out, tick, cfg_ready);
    end
    adv();
    reset = 1'b0;
    for (int k = 0; k < 120; k++) begin
      adv();
      e = (k % 50) < 25;
      checks++;
      if (clk_out !== {e, e} || tick !== {2{(k % 50) == 49}}) begin
        failures++; $display("FAIL areset_resume k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, {e, e}, {2{(k % 50) == 49}});
      end
    end
  endtask

  task automatic test_invalid_channel();
    logic e;
    enable3 = 3'b111; cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_period3 = 16'd7; cfg_high3 = 16'd2; #1;
    for (int k = 0; k < 120; k++) begin
      checks++;
      if (cfg_ready3 !== 1'b1) begin
        failures++; $display("FAIL invalid_ready: cfg_ready=%b expected 1", cfg_ready3);
      end
      adv();
      e = (k % 50) < 25;
      checks++;
      if (clk_out3 !== {3{e}} || tick3 !== {3{(k % 50) == 49}}) begin
        failures++; $display("FAIL invalid_out k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out3, tick3, {3{e}}, {3{(k % 50) == 49}});
      end
      checks++;
      if (clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL invalid_main k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, exp_clk(), exp_tick());
      end
    end
    cfg_valid3 = 1'b0; enable3 = 3'b000;
  endtask

  task automatic test_random();
    enable = 2'b11;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) enable = enable ^ (2'b01 << $urandom_range(0, 1));
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 1'($urandom_range(0, 1));
      cfg_period = 16'($urandom_range(0, 12));
      cfg_high   = 16'($urandom_range(0, 14));
      #1;
      checks++;
      if (cfg_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready k=%0d: cfg_ready=%b expected %b", k, cfg_ready, exp_ready());
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1; model_reset(); #1;
        checks++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
          failures++; $display("FAIL rand_reset: clk_out=%b tick=%b expected 00 00", clk_out, tick);
        end
        adv();
        reset = 1'b0;
      end else begin
        adv();
      end
      checks++;
      if (clk_out !== exp_clk() || tick !== exp_tick()) begin
        failures++; $display("FAIL rand_out k=%0d: clk_out=%b tick=%b expected %b %b", k, clk_out, tick, exp_clk(), exp_tick());
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; enable = 2'b00; cfg_valid = 1'b0; cfg_ch = 1'b0;
    cfg_period = 16'd0; cfg_high = 16'd0;
    enable3 = 3'b000; cfg_valid3 = 1'b0; cfg_ch3 = 2'd0;
    cfg_period3 = 16'd0; cfg_high3 = 16'd0;
    model_reset();
    test_reset();
    test_defaults();
    test_glitch_free();
    test_edge_cases();
    test_back_to_back();
    test_async_reset();
    test_invalid_channel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded 1000000 time units");
    $fatal(1);
  end

endmodule
